// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl
// ----------------------------------------------------------------------------
// Framing controller and output buffer for the serial-in/parallel-out path.
// Qualified serial bits are shifted MSB-first into an internal register. A
// frame starts on a valid bit that carries frame_start. Each completed word
// moves to a holding register and is offered downstream with a valid/ready
// handshake. A word that completes while the holding register is still full
// and not being consumed is dropped, and this sets the sticky overrun flag.
//
// Build option:
//   SIPO_FRAME_PARITY_EN - when defined, each frame is followed by an even
//                          parity bit. parity_err is loaded together with
//                          the word. When undefined, parity_err is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   serial_in    in   serial data bit, used only when serial_valid is high
//   serial_valid in   qualifies serial_in for this cycle
//   frame_start  in   marks the current valid bit as bit 0 of a new frame
//   out_data     out  completed word; first received bit is in the MSB
//   out_valid    out  out_data holds an unconsumed word
//   out_ready    in   consumer accepts out_data when out_valid is also high
//   overrun      out  sticky flag; a completed word was dropped
//   overrun_clr  in   clears overrun (a new overrun in the same cycle wins)
//   busy         out  a frame is in progress
//   parity_err   out  parity status of out_data, meaningful while out_valid
// ----------------------------------------------------------------------------
module sipo_frame_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  busy,
  output logic                  parity_err
);

  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SIPO_FRAME_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]            state, next_state;
  logic [CW-1:0]         count, next_count;
  logic [DATA_WIDTH-1:0] shreg, next_shreg;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] word;
  logic                  complete;
  logic                  restart;
  logic                  handshake;

  assign shifted   = {shreg[DATA_WIDTH-2:0], serial_in};
  assign restart   = serial_valid & frame_start;
  assign handshake = out_valid & out_ready;
  assign busy      = (state != IDLE);

`ifdef SIPO_FRAME_PARITY_EN
  logic perr_next;
  logic parity_q;
`endif

  // The counter cannot hold DATA_WIDTH, so the word completes when the bit
  // arrives while the count is DATA_WIDTH-1. frame_start overrides every
  // state and restarts the frame, which silently discards any partial word.
  always_comb begin
    next_state = state;
    next_count = count;
    next_shreg = shreg;
    complete   = 1'b0;
    word       = shifted;
`ifdef SIPO_FRAME_PARITY_EN
    perr_next  = 1'b0;
`endif
    if (restart) begin
      next_shreg = shifted;
      next_count = CW'(1);
      next_state = SHIFT;
    end else if (serial_valid) begin
      case (state)
        SHIFT: begin
          next_shreg = shifted;
          if (count == CW'(DATA_WIDTH - 1)) begin
            next_count = '0;
`ifdef SIPO_FRAME_PARITY_EN
            next_state = PARITY;
`else
            complete   = 1'b1;
            next_state = IDLE;
`endif
          end else begin
            next_count = count + CW'(1);
          end
        end
`ifdef SIPO_FRAME_PARITY_EN
        // The parity bit is not shifted in; the data word is already whole.
        PARITY: begin
          complete   = 1'b1;
          word       = shreg;
          perr_next  = (^shreg) ^ serial_in;
          next_state = IDLE;
        end
`endif
        default: next_state = state;
      endcase
    end
  end

  // A completed word may load when the holding register is empty or is being
  // emptied by a handshake in the same cycle; otherwise it is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      shreg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state <= next_state;
      count <= next_count;
      shreg <= next_shreg;
      if (complete && (!out_valid || handshake)) begin
        out_data  <= word;
        out_valid <= 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
        parity_q  <= perr_next;
`endif
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (complete && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SIPO_FRAME_PARITY_EN
  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Framing controller and output buffer for the serial-in/parallel-out shift register path. It accepts a qualified serial bit stream with a start-of-frame marker and counts `DATA_WIDTH` bits into an internal shift register. It transfers each completed word into a holding register and presents it downstream through a valid/ready handshake, flagging any word lost to backpressure. It sits between the serial line front end and any parallel consumer of deserialized words.

## Interface
- `DATA_WIDTH`, 16, word width in bits; must be ≥ 2.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `serial_in`  input  1  serial data bit, sampled only when `serial_valid`=1.
- `serial_valid`  input  1  qualifies `serial_in` for the current cycle.
- `frame_start`  input  1  marks the current valid bit as bit 0 of a new frame; ignored when `serial_valid`=0.
- `out_data`  output  DATA_WIDTH  completed word; first received bit is in the MSB.
- `out_valid`  output  1  `out_data` holds an unconsumed word.
- `out_ready`  input  1  consumer accepts `out_data` when high together with `out_valid`.
- `overrun`  output  1  sticky; a completed word was dropped.
- `overrun_clr`  input  1  clears `overrun`.
- `busy`  output  1  a frame is in progress (state ≠ IDLE).
- `parity_err`  output  1  parity status of the word in `out_data`, valid while `out_valid`=1.

## Operation
- Shift register: on each accepted bit, `shreg <= {shreg[DATA_WIDTH-2:0], serial_in}`. Bit counter width is `$clog2(DATA_WIDTH)`.
- States:
  - IDLE: waits for `serial_valid & frame_start`. That bit is shifted in, count goes to 1, and the FSM enters SHIFT.
  - SHIFT: each `serial_valid` cycle shifts one bit and increments the count. Cycles with `serial_valid`=0 stall with no change. When the bit that brings the count to `DATA_WIDTH` is accepted, the word completes. With parity disabled, the FSM returns to IDLE. With parity enabled, it enters PARITY.
  - PARITY (parity build only): the next valid bit is the parity bit, the word completes, and the FSM returns to IDLE.
- `frame_start` asserted with `serial_valid` while in SHIFT or PARITY:
  - The partial frame is discarded without signalling.
  - The current bit becomes bit 0 of a new frame, the count goes to 1, and the FSM stays in or goes to SHIFT.
- Word completion:
  - If `out_valid`=0, or the current cycle is a handshake (`out_valid & out_ready`), the word loads into `out_data` and `out_valid` is 1 after the edge.
  - Otherwise the new word is dropped, `out_data` is unchanged, and `overrun` is set.
- Handshake without a completion: `out_valid & out_ready` clears `out_valid`.
- `overrun_clr` clears `overrun`. A simultaneous new overrun event wins, and `overrun` stays 1.

## Timing
- Reset values:
  - `out_data`=0, `out_valid`=0, `overrun`=0, `busy`=0, `parity_err`=0.
  - FSM in IDLE, count=0, `shreg`=0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). The first frame after release must start with a new `frame_start`.
- Latency:
  - `out_valid` rises on the edge that samples the last data bit, or the parity bit in the parity build.
  - The word is visible in the following cycle.
  - With contiguous `serial_valid`, frames run back to back with no idle cycle: `frame_start` may accompany the bit immediately after the completing bit.
- `out_data` and `parity_err` are stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` does not depend combinationally on `out_ready`.
- `busy` is high from the edge after the first bit is accepted until the edge of word completion.

## Configuration
- Macro: `SIPO_FRAME_PARITY_EN`.
- Defined:
  - PARITY state is present, and each frame is `DATA_WIDTH`+1 bits.
  - Even parity is checked over the data bits plus the parity bit.
  - `parity_err` is loaded with the word: 1 if the XOR of all `DATA_WIDTH`+1 bits is 1.
  - A word with a parity error is still delivered.
- Undefined:
  - No PARITY state; frames are `DATA_WIDTH` bits.
  - `parity_err` is tied to 0.

## Test plan
- Reset, then send 0xA5C3 MSB-first on 16 contiguous valid cycles (`frame_start` on the first) with `out_ready`=1. Required: `out_data`=0xA5C3 and `out_valid`=1 for exactly one cycle after the 16th bit edge; `busy` drops on the same edge.
- Same word with `serial_valid` low every other cycle. Required: identical 0xA5C3 after 32 cycles; no bit is skipped or duplicated.
- `out_ready`=0, send 0x1234 then 0xFFFF. Required: `out_data` stays 0x1234 and `overrun`=1. Then raise `out_ready` for one cycle and pulse `overrun_clr`. Required: `out_valid`=0 and `overrun`=0.
- Send 8 bits of 0xAB, then assert `frame_start` and send a full 0x00FF frame. Required: only 0x00FF is delivered, with `overrun`=0.
- Assert `reset` after 10 bits of a frame. Required: all outputs return to 0 immediately; a following complete 0x5555 frame is delivered correctly.
- With `SIPO_FRAME_PARITY_EN` defined, send 0x0001 with parity bit 1, then 0x0001 with parity bit 0. Required: `parity_err`=0 for the first word and 1 for the second; both words are delivered.
